// File: rtl/sme_multi.sv
// sme_multi: string-matching engine. Stores one string, then matches any number of
// patterns against it. Patterns support '.', leading '^' and trailing '$'. Mode 0
// reports the first match; mode 1 reports every match followed by a match count.
module sme_multi #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned IDX_W   = $clog2(STR_MAX + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_chardata,
  input  logic             i_isstring,
  input  logic             i_ispattern,
  input  logic             i_mode,
  output logic             o_valid,
  output logic             o_match,
  output logic [IDX_W-1:0] o_match_index,
  output logic             o_last
);

  // Length/position width must hold L+1 (candidate count with an empty body).
  localparam int unsigned LW   = $clog2(STR_MAX + 2);
  localparam int unsigned PW   = $clog2(PAT_MAX + 1);
  localparam int          SMax = int'(STR_MAX);
  localparam int          PMax = int'(PAT_MAX);

  localparam logic [7:0] ChDot    = 8'h2E;
  localparam logic [7:0] ChCaret  = 8'h5E;
  localparam logic [7:0] ChDollar = 8'h24;
  localparam logic [7:0] ChSpace  = 8'h20;

  typedef enum logic [1:0] {
    StIdle,
    StRdStr,
    StRdPat,
    StScan
  } state_e;

  state_e r_state, w_state_d;

  logic [7:0]       r_str [STR_MAX];
  logic [7:0]       r_pat [PAT_MAX];
  logic [LW-1:0]    r_len, w_len_d;
  logic [PW-1:0]    r_plen, w_plen_d;
  logic             r_mode, w_mode_d;
  logic [LW-1:0]    r_pos, w_pos_d;
  logic             r_done, w_done_d;
  logic [IDX_W-1:0] r_count, w_count_d;
  logic             r_prev_str;

  logic             r_valid, w_valid_d;
  logic             r_match, w_match_d;
  logic [IDX_W-1:0] r_idx, w_idx_d;
  logic             r_last, w_last_d;

  // Storage write controls
  logic             w_str_we;
  logic [LW-1:0]    w_str_waddr;
  logic             w_pat_we;
  logic [PW-1:0]    w_pat_waddr;

  // FSM helper strobes
  logic             w_start_str;
  logic             w_start_pat;
  logic             w_do_scan;

  // Pattern decode and candidate evaluation
  logic             w_anc_s;
  logic             w_anc_e;
  int               w_lb;
  int               w_ncand;
  int               w_p;
  logic [PAT_MAX-1:0] w_ok;
  logic             w_hit;

  // Bounded read of the string store; out-of-range positions read as NUL.
  function automatic logic [7:0] str_at(input int idx);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < SMax; i++) begin
      if (i == idx) c = r_str[i];
    end
    return c;
  endfunction

  // Bounded read of the pattern store; out-of-range positions read as NUL.
  function automatic logic [7:0] pat_at(input int idx);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < PMax; i++) begin
      if (i == idx) c = r_pat[i];
    end
    return c;
  endfunction

  // Decode anchors, body length and number of candidate positions
  always_comb begin
    w_anc_s = (r_plen != '0) && (r_pat[0] == ChCaret);
    w_anc_e = 1'b0;
    for (int k = 0; k < PMax; k++) begin
      if ((k + 1) == int'(r_plen) && r_pat[k] == ChDollar) w_anc_e = 1'b1;
    end
    w_lb    = int'(r_plen) - int'(w_anc_s) - int'(w_anc_e);
    w_p     = int'(r_pos);
    w_ncand = ((r_len != '0) && (w_lb <= int'(r_len))) ? int'(r_len) - w_lb + 1 : 0;
  end

  // One comparator per body character, all evaluated in parallel for candidate r_pos
  always_comb begin
    logic [7:0] bc;
    bc   = 8'h00;
    w_ok = '0;
    for (int k = 0; k < PMax; k++) begin
      bc      = w_anc_s ? pat_at(k + 1) : pat_at(k);
      w_ok[k] = (k >= w_lb) || (bc == ChDot) || (bc == str_at(w_p + k));
    end
  end

  // Combine body comparison with word-boundary anchor checks
  always_comb begin
    w_hit = &w_ok;
    if (w_anc_s && (w_p != 0) && (str_at(w_p - 1) != ChSpace)) w_hit = 1'b0;
    if (w_anc_e && ((w_p + w_lb) != int'(r_len)) && (str_at(w_p + w_lb) != ChSpace)) begin
      w_hit = 1'b0;
    end
  end

  // Next-state, storage write controls and registered result values
  always_comb begin
    w_state_d   = r_state;
    w_len_d     = r_len;
    w_plen_d    = r_plen;
    w_mode_d    = r_mode;
    w_pos_d     = r_pos;
    w_done_d    = r_done;
    w_count_d   = r_count;
    w_valid_d   = 1'b0;
    w_match_d   = 1'b0;
    w_idx_d     = '0;
    w_last_d    = 1'b0;
    w_str_we    = 1'b0;
    w_str_waddr = '0;
    w_pat_we    = 1'b0;
    w_pat_waddr = '0;
    w_start_str = 1'b0;
    w_start_pat = 1'b0;
    w_do_scan   = 1'b0;

    case (r_state)
      StIdle: begin
        if (i_isstring) w_start_str = 1'b1;
      end
      StRdStr: begin
        if (i_isstring) begin
          // A gap in isstring followed by a new strobe begins a fresh string.
          if (!r_prev_str) begin
            w_start_str = 1'b1;
          end else if (int'(r_len) < SMax) begin
            w_str_we    = 1'b1;
            w_str_waddr = r_len;
            w_len_d     = r_len + LW'(1);
          end
        end else if (i_ispattern) begin
          w_start_pat = 1'b1;
        end
      end
      StRdPat: begin
        if (i_ispattern) begin
          if (int'(r_plen) < PMax) begin
            w_pat_we    = 1'b1;
            w_pat_waddr = r_plen;
            w_plen_d    = r_plen + PW'(1);
          end
        end else begin
          // The first cycle without ispattern already evaluates candidate 0.
          w_do_scan = 1'b1;
          w_state_d = StScan;
        end
      end
      StScan: begin
        if (r_done) begin
          if (i_isstring) begin
            w_start_str = 1'b1;
          end else if (i_ispattern) begin
            w_start_pat = 1'b1;
          end
        end else begin
          w_do_scan = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_start_str) begin
      w_str_we    = 1'b1;
      w_str_waddr = '0;
      w_len_d     = LW'(1);
      w_state_d   = StRdStr;
    end

    if (w_start_pat) begin
      w_pat_we    = 1'b1;
      w_pat_waddr = '0;
      w_plen_d    = PW'(1);
      w_mode_d    = i_mode;
      w_pos_d     = '0;
      w_count_d   = '0;
      w_done_d    = 1'b0;
      w_state_d   = StRdPat;
    end

    if (w_do_scan) begin
      if (w_p < w_ncand) begin
        if (!r_mode) begin
          if (w_hit) begin
            w_valid_d = 1'b1;
            w_match_d = 1'b1;
            w_idx_d   = IDX_W'(w_p);
            w_last_d  = 1'b1;
            w_done_d  = 1'b1;
          end else if (w_p == w_ncand - 1) begin
            w_valid_d = 1'b1;
            w_last_d  = 1'b1;
            w_done_d  = 1'b1;
          end else begin
            w_pos_d = LW'(w_p + 1);
          end
        end else begin
          if (w_hit) begin
            w_valid_d = 1'b1;
            w_match_d = 1'b1;
            w_idx_d   = IDX_W'(w_p);
            if (r_count != '1) w_count_d = r_count + IDX_W'(1);
          end
          w_pos_d = LW'(w_p + 1);
        end
      end else begin
        // Candidates exhausted (or none existed): terminal pulse.
        w_valid_d = 1'b1;
        w_idx_d   = r_mode ? r_count : '0;
        w_last_d  = 1'b1;
        w_done_d  = 1'b1;
      end
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_len      <= '0;
      r_plen     <= '0;
      r_mode     <= 1'b0;
      r_pos      <= '0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_prev_str <= 1'b0;
      r_valid    <= 1'b0;
      r_match    <= 1'b0;
      r_idx      <= '0;
      r_last     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_len      <= w_len_d;
      r_plen     <= w_plen_d;
      r_mode     <= w_mode_d;
      r_pos      <= w_pos_d;
      r_done     <= w_done_d;
      r_count    <= w_count_d;
      r_prev_str <= i_isstring;
      r_valid    <= w_valid_d;
      r_match    <= w_match_d;
      r_idx      <= w_idx_d;
      r_last     <= w_last_d;
    end
  end

  // Character stores; contents beyond L/P are never read, so no reset is needed
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < SMax; i++) begin
      if (w_str_we && (i == int'(w_str_waddr))) r_str[i] <= i_chardata;
    end
    for (int i = 0; i < PMax; i++) begin
      if (w_pat_we && (i == int'(w_pat_waddr))) r_pat[i] <= i_chardata;
    end
  end

  assign o_valid       = r_valid;
  assign o_match       = r_match;
  assign o_match_index = r_idx;
  assign o_last        = r_last;

endmodule

// File: tb/tb_sme_multi.sv
// Scoreboard bench for sme_multi: stimulus pushes expected pulses (value and cycle)
// computed from a string-level reference model; a monitor pops and compares.
module tb_sme_multi;
  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int IDX_W   = $clog2(STR_MAX + 1);
  localparam int CNT_MAX = (1 << IDX_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       chardata = 8'h00;
  logic             isstring = 1'b0;
  logic             ispattern = 1'b0;
  logic             mode = 1'b0;
  logic             valid;
  logic             match;
  logic [IDX_W-1:0] match_index;
  logic             last;

  sme_multi #(
    .STR_MAX(STR_MAX),
    .PAT_MAX(PAT_MAX),
    .IDX_W  (IDX_W)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_chardata   (chardata),
    .i_isstring   (isstring),
    .i_ispattern  (ispattern),
    .i_mode       (mode),
    .o_valid      (valid),
    .o_match      (match),
    .o_match_index(match_index),
    .o_last       (last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit m;
    int idx;
    bit last;
    int cyc;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  string cur_s = "";

  // Monitor: compare every pulse against the head of the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got m=%0b idx=%0d last=%0b, none expected",
                   cyc, match, match_index, last);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (match !== e.m || int'(match_index) != e.idx || last !== e.last || cyc != e.cyc)
          begin
            errors++;
            $display("FAIL pulse got m=%0b idx=%0d last=%0b cyc=%0d exp m=%0b idx=%0d last=%0b cyc=%0d",
                     match, match_index, last, cyc, e.m, e.idx, e.last, e.cyc);
          end
        end
      end else begin
        checks++;
        if (match !== 1'b0 || last !== 1'b0 || match_index !== '0) begin
          errors++;
          $display("FAIL idle_zero cyc=%0d got m=%0b idx=%0d last=%0b exp all 0",
                   cyc, match, match_index, last);
        end
        if (q.size() != 0 && cyc >= q[0].cyc) begin
          errors++;
          $display("FAIL missing_pulse cyc=%0d got valid=0 exp m=%0b idx=%0d last=%0b",
                   cyc, q[0].m, q[0].idx, q[0].last);
          void'(q.pop_front());
        end
      end
    end
  end

  function automatic void push_exp(bit m, int idx, bit lst, int c);
    exp_t e;
    e.m = m;
    e.idx = idx;
    e.last = lst;
    e.cyc = c;
    q.push_back(e);
  endfunction

  // Reference: does body b (with anchors) occur at position p of s[0..L-1]?
  function automatic bit cand_ok(string s, int l, string b, bit as, bit ae, int p);
    int lb;
    lb = b.len();
    for (int k = 0; k < lb; k++) begin
      if (b[k] != 8'h2E && b[k] != s[p+k]) return 1'b0;
    end
    if (as && p != 0 && s[p-1] != 8'h20) return 1'b0;
    if (ae && p + lb != l && s[p+lb] != 8'h20) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: expected pulses for pattern pt against s, scan starting in cycle t
  function automatic void model(string s, string pt, bit m, int t);
    int    l, plen, lb, n, cnt;
    bit    as, ae, found;
    string pp, body;
    l     = (s.len() > STR_MAX) ? STR_MAX : s.len();
    plen  = (pt.len() > PAT_MAX) ? PAT_MAX : pt.len();
    pp    = pt.substr(0, plen - 1);
    as    = (plen > 0) && (pp[0] == 8'h5E);
    ae    = (plen > 0) && (pp[plen-1] == 8'h24);
    lb    = plen - int'(as) - int'(ae);
    body  = (lb > 0) ? pp.substr(int'(as), int'(as) + lb - 1) : "";
    n     = (l > 0 && lb <= l) ? l - lb + 1 : 0;
    cnt   = 0;
    found = 1'b0;
    for (int p = 0; p < n; p++) begin
      if (!found && cand_ok(s, l, body, as, ae, p)) begin
        if (!m) begin
          push_exp(1'b1, p, 1'b1, t + p + 1);
          found = 1'b1;
        end else begin
          push_exp(1'b1, p, 1'b0, t + p + 1);
          cnt++;
        end
      end
    end
    if (!m && !found) push_exp(1'b0, 0, 1'b1, (n == 0) ? t + 1 : t + n);
    if (m) push_exp(1'b0, (cnt > CNT_MAX) ? CNT_MAX : cnt, 1'b1, (n == 0) ? t + 1 : t + n + 1);
  endfunction

  // All drive tasks are entered and left 1 time unit after a rising edge.
  task automatic load_str(input string s);
    cur_s = s;
    for (int i = 0; i < s.len(); i++) begin
      isstring = 1'b1;
      chardata = s[i];
      @(posedge clk);
      #1;
    end
    isstring = 1'b0;
    chardata = 8'h00;
  endtask

  task automatic drive_pat(input string p, input bit m, output int t);
    mode = m;
    for (int i = 0; i < p.len(); i++) begin
      ispattern = 1'b1;
      chardata  = p[i];
      @(posedge clk);
      #1;
    end
    ispattern = 1'b0;
    chardata  = 8'h00;
    t = cyc;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL timeout got %0d pulses outstanding exp 0", q.size());
      q.delete();
    end
    #1;
  endtask

  task automatic run_pat(input string p, input bit m, input bit inject);
    int t;
    drive_pat(p, m, t);
    model(cur_s, p, m, t);
    if (inject) begin
      // String strobes during an active scan must be ignored.
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        isstring = 1'b1;
        chardata = 8'h7A;
        @(posedge clk);
        #1;
      end
      isstring = 1'b0;
      chardata = 8'h00;
    end
    wait_done();
  endtask

  function automatic string rnd_str(int n, string alph);
    string s;
    s = "";
    for (int i = 0; i < n; i++) begin
      s = $sformatf("%s%c", s, alph[$urandom_range(alph.len() - 1, 0)]);
    end
    return s;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    int    t;
    string s, p;

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || match !== 1'b0 || last !== 1'b0 || match_index !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%0b m=%0b idx=%0d last=%0b exp 0", valid, match,
               match_index, last);
    end
    mon_en = 1'b1;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    load_str("the quick");
    run_pat("qu.ck", 1'b0, 1'b0);
    load_str("aba aba");
    run_pat("ab", 1'b1, 1'b0);
    load_str("aba abab");
    run_pat("^aba$", 1'b0, 1'b0);
    run_pat("ab$", 1'b0, 1'b0);
    run_pat("^b", 1'b0, 1'b0);
    run_pat("b.b", 1'b1, 1'b0);

    // String overflow: L saturates at 32, so "xyz" at 35 is lost
    s = "";
    for (int i = 0; i < 35; i++) s = {s, "a"};
    s = {s, "xyzaa"};
    load_str(s);
    run_pat("xyz", 1'b0, 1'b0);
    run_pat("a$", 1'b0, 1'b0);
    run_pat(".", 1'b1, 1'b0);

    // Pattern overflow: body truncated to 8 characters
    load_str("abcdefgh");
    run_pat("abcdefghij", 1'b0, 1'b0);

    // Strobes during scan are ignored
    load_str("aaaaaaaa");
    run_pat("a", 1'b1, 1'b1);
    run_pat("aa", 1'b1, 1'b0);

    // Reset during a find-all scan: only pulses up to T+3 survive
    drive_pat("a", 1'b1, t);
    model(cur_s, "a", 1'b1, t);
    while (q.size() != 0 && q[q.size()-1].cyc > t + 3) void'(q.pop_back());
    while (cyc < t + 3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL reset_abort got %0d pulses outstanding exp 0", q.size());
      q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
    load_str("abc");
    run_pat("b", 1'b0, 1'b0);

    // Randomized patterns against randomized strings
    for (int it = 0; it < 40; it++) begin
      if (it % 5 == 0) load_str(rnd_str($urandom_range(40, 1), "ab "));
      p = rnd_str($urandom_range(9, 0), "ab.");
      if ($urandom_range(2, 0) == 0) p = {"^", p};
      if ($urandom_range(2, 0) == 0) p = {p, "$"};
      if (p.len() == 0) p = "a";
      run_pat(p, 1'($urandom_range(1, 0)), 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sme_multi.md
# sme_multi

Parametrised string-matching engine, successor to the single-result SME block. A string is loaded, then one or more patterns are matched against it. Patterns support the `.`, `^` and `$` wildcards. Depth is configurable, and a find-all mode reports every match position followed by a match count. It sits on the same character-stream input bus as the existing engine and drives a registered valid/result output.

## Interface
- STR_MAX, 32: maximum stored string length in characters.
- PAT_MAX, 8: maximum pattern length in characters, including anchors.
- IDX_W, $clog2(STR_MAX+1): width of match_index.

- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- chardata  in  8  ASCII character, valid while isstring or ispattern is high.
- isstring  in  1  string character strobe; consecutive high cycles form one string.
- ispattern  in  1  pattern character strobe; consecutive high cycles form one pattern.
- mode  in  1  0 = first-match, 1 = find-all; sampled with the first pattern character.
- valid  out  1  result pulse, one cycle per result.
- match  out  1  1 = match at match_index; 0 = terminal/no-match pulse.
- match_index  out  IDX_W  match position, or match count on the find-all terminal pulse.
- last  out  1  marks the final result pulse for the current pattern.

## Operation
- States:
  - IDLE
  - RD_STR: string is stored at positions 0..L-1.
  - RD_PAT: pattern is stored at positions 0..P-1.
  - SCAN
- Transitions:
  - IDLE→RD_STR on isstring.
  - RD_STR→RD_PAT on ispattern.
  - RD_PAT→SCAN on the first cycle with ispattern low.
  - SCAN→RD_STR on isstring, after the last pulse.
  - SCAN→RD_PAT on ispattern, after the last pulse.
- A new string (isstring rising) clears the old string and resets L to 0. A new pattern reuses the stored string.
- Overflow:
  - String characters beyond STR_MAX are dropped; L saturates at STR_MAX.
  - Pattern characters beyond PAT_MAX are dropped.
- Anchors:
  - Pattern[0]==0x5E (`^`) sets anchor-start and is stripped.
  - Last stored pattern char==0x24 (`$`) sets anchor-end and is stripped.
  - The remaining body B has length Lb.
- Candidate p, for p = 0..L-Lb, matches when all of these hold:
  - Every body char k is 0x2E (`.`) or equals S[p+k].
  - anchor-start ⇒ p==0 or S[p-1]==0x20.
  - anchor-end ⇒ p+Lb==L or S[p+Lb]==0x20.
- One candidate is evaluated per SCAN cycle, in ascending p. All PAT_MAX comparators operate in parallel.
- mode 0:
  - First match emits valid=1, match=1, match_index=p, last=1, and scanning stops.
  - No match emits a single valid=1, match=0, match_index=0, last=1.
- mode 1:
  - Each match emits valid=1, match=1, match_index=p, last=0.
  - After the final candidate, a terminal pulse valid=1, match=0, last=1, match_index=count is emitted.
  - count saturates at 2^IDX_W-1.
- Lb>L or L==0: no candidates. Only the terminal/no-match pulse is emitted (count 0).
- isstring or ispattern asserted during SCAN before last: the characters are ignored and the scan continues.

## Timing
- Reset is sampled on clk with reset==0. It sets:
  - state=IDLE, valid=0, match=0, match_index=0, last=0.
  - L=0, P=0, count=0.
- Reset during SCAN aborts the scan; no further pulses are emitted.
- Let T be the first cycle with ispattern low after the pattern, and N = max(L-Lb+1, 0).
- Candidate p is evaluated in cycle T+p. Its result pulse is registered and appears in cycle T+p+1.
- mode 0:
  - Match at p: pulse at T+p+1.
  - No match: pulse at T+N, or T+1 when N==0.
- mode 1:
  - Match pulses can be back-to-back; there is no stall.
  - Terminal pulse at T+N+1, or T+1 when N==0.
- Outputs are 0 whenever valid==0.
- A new string or pattern may start in the cycle after the last pulse.

## Test plan
- String "the quick", pattern "qu.ck", mode 0 → one pulse: match=1, index=4, last=1, at T+5.
- String "aba aba", pattern "ab", mode 1 → pulses index 0 (T+1) and index 4 (T+5), then terminal match=0, index=2, last=1 at T+7.
- String "aba abab", then sequential patterns:
  - "^aba$", mode 0 → match, index 0.
  - "ab$", mode 0 → match, index 6.
  - "^b" → no match, last=1.
- STR_MAX=32 with a 40-char string whose "xyz" sits at position 35; pattern "xyz" → no-match pulse, and L stays 32.
- Pattern "abcdefghij" (10 chars, PAT_MAX=8) against "abcdefgh" → truncated body matches, index 0.
- String "aaaaaaaa", pattern "a", mode 1; reset driven low at T+3 → pulses at T+1..T+3 only. Outputs are 0 from T+4; no terminal pulse. The engine then accepts a new string.
